fb_write_arbiter: RTL and testbench

//  Shares the single-port framebuffer RAM between processor framebuffer stores (d_fb_write path, EX stage)
//  and display scanout reads. Stores are formatted into byte-lane writes and buffered in a small queue;

---
 rtl/display_processor_pkg.sv | 55 +++++
 rtl/fb_write_arbiter_if.sv | 29 ++
 rtl/fb_store_fifo.sv | 45 ++++
 rtl/fb_write_arbiter.sv | 116 +++++++++++
 tb/tb_fb_write_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/display_processor_pkg.sv
// Shared display-processor types: store size encoding, framebuffer write-queue entry,
// write-arbiter state, and the store-to-byte-lane formatting helpers.
package display_processor_pkg;

  localparam int FB_ADDR_W = 17;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_t;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [3:0]           we;
    logic [31:0]          wdata;
  } fb_wr_entry_t;

  typedef enum logic {
    ARB_NORMAL,
    ARB_FORCE_WR
  } fb_arb_state_t;

  function automatic logic fb_store_misaligned(input logic [1:0] lane, input mem_size_t size);
    case (size)
      MEM_BYTE: return 1'b0;
      MEM_HALF: return lane[0];
      default:  return lane != 2'b00;
    endcase
  endfunction

  // Lane replication lets the RAM pick the right bytes purely from the write enables.
  function automatic fb_wr_entry_t fb_format_store(input logic [FB_ADDR_W+1:0] byte_addr,
                                                   input logic [31:0]          data,
                                                   input mem_size_t            size);
    fb_wr_entry_t e;
    e.addr = byte_addr[FB_ADDR_W+1:2];
    case (size)
      MEM_BYTE: begin
        e.we    = 4'b0001 << byte_addr[1:0];
        e.wdata = {4{data[7:0]}};
      end
      MEM_HALF: begin
        e.we    = byte_addr[1] ? 4'b1100 : 4'b0011;
        e.wdata = {2{data[15:0]}};
      end
      default: begin
        e.we    = 4'b1111;
        e.wdata = data;
      end
    endcase
    return e;
  endfunction

endpackage

// File: rtl/fb_write_arbiter_if.sv
// Requester-side bundle of the framebuffer arbiter: CPU store path and scanout read path.
interface fb_write_arbiter_if
  import display_processor_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W
);
  logic              e_fb_write;
  logic [ADDR_W+1:0] e_addr;
  logic [31:0]       e_wdata;
  mem_size_t         e_mem_size;
  logic              cpu_stall;
  logic              fb_misalign;

  logic              so_req;
  logic [ADDR_W-1:0] so_addr;
  logic              so_gnt;
  logic              so_rvalid;
  logic [31:0]       so_rdata;

  modport master (
    output e_fb_write, e_addr, e_wdata, e_mem_size, so_req, so_addr,
    input  cpu_stall, fb_misalign, so_gnt, so_rvalid, so_rdata
  );

  modport slave (
    input  e_fb_write, e_addr, e_wdata, e_mem_size, so_req, so_addr,
    output cpu_stall, fb_misalign, so_gnt, so_rvalid, so_rdata
  );
endinterface

// File: rtl/fb_store_fifo.sv
// Synchronous FIFO of formatted framebuffer writes; head is visible combinationally.
// Callers must not push when full nor pop when empty.
module fb_store_fifo
  import display_processor_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fb_wr_entry_t push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output fb_wr_entry_t head
);
  localparam int PTR_W = $clog2(DEPTH);

  fb_wr_entry_t       mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;

  // NOTE: storage carries no reset; only pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  assign full  = count == (PTR_W+1)'(DEPTH);
  assign empty = count == '0;
  assign head  = mem[rd_ptr];
endmodule

// File: rtl/fb_write_arbiter.sv
// Single-port framebuffer arbiter: scanout reads win, queued CPU stores get a forced slot
// after MAX_DEFER blocked cycles. Define FB_ARB_STATS_EN to add stall/forced-write counters.
module fb_write_arbiter
  import display_processor_pkg::*;
#(
  parameter int ADDR_W     = FB_ADDR_W,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_DEFER  = 8
) (
  input  logic              clk,
  input  logic              rst,
  fb_write_arbiter_if.slave bus,
  output logic              fb_en,
  output logic [3:0]        fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [31:0]       fb_wdata,
  input  logic [31:0]       fb_rdata
`ifdef FB_ARB_STATS_EN
  ,
  output logic [31:0]       stat_stall_cycles,
  output logic [15:0]       stat_forced_wr
`endif
);
  localparam int DEFER_W = $clog2(MAX_DEFER + 1);

  fb_arb_state_t      state, state_nxt;
  logic [DEFER_W-1:0] defer_cnt, defer_cnt_nxt;
  fb_wr_entry_t       store_entry, head;
  logic               full, empty, misaligned, push, pop, so_gnt, so_rvalid_q;

  assign misaligned  = fb_store_misaligned(bus.e_addr[1:0], bus.e_mem_size);
  assign store_entry = fb_format_store(bus.e_addr, bus.e_wdata, bus.e_mem_size);

  // Fullness is the registered count, so a same-cycle pop never frees a slot for the pusher.
  assign push            = !rst && bus.e_fb_write && !full && !misaligned;
  assign bus.cpu_stall   = !rst && bus.e_fb_write && full;
  assign bus.fb_misalign = !rst && bus.e_fb_write && !full && misaligned;

  fb_store_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (store_entry),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt     = state;
    defer_cnt_nxt = defer_cnt;
    so_gnt        = 1'b0;
    pop           = 1'b0;
    if (!rst) begin
      case (state)
        ARB_NORMAL: begin
          if (bus.so_req) begin
            so_gnt = 1'b1;
            if (empty) begin
              defer_cnt_nxt = '0;
            end else if (defer_cnt == DEFER_W'(MAX_DEFER - 1)) begin
              state_nxt = ARB_FORCE_WR;
            end else begin
              defer_cnt_nxt = defer_cnt + DEFER_W'(1);
            end
          end else begin
            pop           = !empty;
            defer_cnt_nxt = '0;
          end
        end
        ARB_FORCE_WR: begin
          pop           = !empty;
          defer_cnt_nxt = '0;
          state_nxt     = ARB_NORMAL;
        end
        default: state_nxt = ARB_NORMAL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ARB_NORMAL;
      defer_cnt   <= '0;
      so_rvalid_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      defer_cnt   <= defer_cnt_nxt;
      so_rvalid_q <= so_gnt;
    end
  end

  assign fb_en         = so_gnt || pop;
  assign fb_we         = pop ? head.we : 4'b0000;
  assign fb_addr       = pop ? head.addr : bus.so_addr;
  assign fb_wdata      = pop ? head.wdata : 32'h0;
  assign bus.so_gnt    = so_gnt;
  assign bus.so_rvalid = so_rvalid_q;
  assign bus.so_rdata  = so_rvalid_q ? fb_rdata : 32'h0;

`ifdef FB_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_stall_cycles <= '0;
      stat_forced_wr    <= '0;
    end else begin
      if (bus.cpu_stall && stat_stall_cycles != '1)
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
      if (state == ARB_NORMAL && state_nxt == ARB_FORCE_WR && stat_forced_wr != '1)
        stat_forced_wr <= stat_forced_wr + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a queue-based reference model.
`timescale 1ns/1ps
module tb_fb_write_arbiter;
  import display_processor_pkg::*;

  localparam int ADDR_W    = 17;
  localparam int DEPTH     = 4;
  localparam int MAX_DEFER = 8;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [3:0]        we;
    logic [31:0]       wdata;
  } st_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              fb_en;
  logic [3:0]        fb_we;
  logic [ADDR_W-1:0] fb_addr;
  logic [31:0]       fb_wdata;
  logic [31:0]       fb_rdata;
`ifdef FB_ARB_STATS_EN
  logic [31:0]       stat_stall_cycles;
  logic [15:0]       stat_forced_wr;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fb_write_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  fb_write_arbiter #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .MAX_DEFER(MAX_DEFER)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .fb_en    (fb_en),
    .fb_we    (fb_we),
    .fb_addr  (fb_addr),
    .fb_wdata (fb_wdata),
    .fb_rdata (fb_rdata)
`ifdef FB_ARB_STATS_EN
    ,
    .stat_stall_cycles (stat_stall_cycles),
    .stat_forced_wr    (stat_forced_wr)
`endif
  );

  // RAM stand-in: reads return an address-derived pattern one cycle later.
  function automatic logic [31:0] ram_val(input logic [ADDR_W-1:0] a);
    return ({15'h0, a} * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  always @(posedge clk) begin
    if (fb_en && fb_we == 4'b0000) fb_rdata <= ram_val(fb_addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_misaligned(input logic [ADDR_W+1:0] a, input mem_size_t s);
    int lane;
    lane = int'(a[1:0]);
    return (s == MEM_HALF && (lane % 2) == 1) || (s == MEM_WORD && lane != 0);
  endfunction

  function automatic st_t model_store(input logic [ADDR_W+1:0] a, input logic [31:0] d,
                                      input mem_size_t s);
    st_t r;
    int  lane;
    lane   = int'(a[1:0]);
    r.addr = ADDR_W'(a / 4);
    case (s)
      MEM_BYTE: begin
        r.we    = 4'(1 << lane);
        r.wdata = {24'h0, d[7:0]} * 32'h01010101;
      end
      MEM_HALF: begin
        r.we    = 4'(3 << lane);
        r.wdata = {16'h0, d[15:0]} * 32'h00010001;
      end
      default: begin
        r.we    = 4'hF;
        r.wdata = d;
      end
    endcase
    return r;
  endfunction

  // Reference model: queue of pending writes, count of consecutive blocked cycles.
  st_t         mq[$];
  int          blocked    = 0;
  bit          force_wr   = 0;
  bit          exp_rvalid = 0;
  logic [31:0] exp_rdata  = '0;
  int          exp_stalls = 0;
  int          exp_forced = 0;
  bit          model_en   = 0;

  initial begin
    bit e_full, e_empty, mis, e_stall, e_mis, e_wr, e_gnt;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        mq.delete();
        blocked    = 0;
        force_wr   = 0;
        exp_rvalid = 0;
        exp_stalls = 0;
        exp_forced = 0;
        model_en   = 1;
      end else if (model_en) begin
        e_full  = mq.size() == DEPTH;
        e_empty = mq.size() == 0;
        mis     = model_misaligned(bus.e_addr, bus.e_mem_size);
        e_stall = bus.e_fb_write && e_full;
        e_mis   = bus.e_fb_write && !e_full && mis;
        e_gnt   = !force_wr && bus.so_req;
        e_wr    = !e_empty && (force_wr || !bus.so_req);

        check("m_cpu_stall", 32'(bus.cpu_stall), 32'(e_stall));
        check("m_fb_misalign", 32'(bus.fb_misalign), 32'(e_mis));
        check("m_so_gnt", 32'(bus.so_gnt), 32'(e_gnt));
        check("m_so_rvalid", 32'(bus.so_rvalid), 32'(exp_rvalid));
        check("m_fb_en", 32'(fb_en), 32'(e_wr || e_gnt));
        if (exp_rvalid) check("m_so_rdata", bus.so_rdata, exp_rdata);
        if (e_wr) begin
          check("m_wr_we", 32'(fb_we), 32'(mq[0].we));
          check("m_wr_addr", 32'(fb_addr), 32'(mq[0].addr));
          check("m_wr_wdata", fb_wdata, mq[0].wdata);
        end else begin
          check("m_fb_we_zero", 32'(fb_we), 32'h0);
          if (e_gnt) check("m_so_addr", 32'(fb_addr), 32'(bus.so_addr));
        end
`ifdef FB_ARB_STATS_EN
        check("m_stat_stall", stat_stall_cycles, 32'(exp_stalls));
        check("m_stat_forced", 32'(stat_forced_wr), 32'(exp_forced));
`endif
        exp_rvalid = e_gnt;
        exp_rdata  = ram_val(bus.so_addr);
        if (e_stall) exp_stalls++;
        if (force_wr) begin
          force_wr = 0;
          blocked  = 0;
        end else if (bus.so_req && !e_empty) begin
          blocked++;
          if (blocked == MAX_DEFER) begin
            force_wr = 1;
            blocked  = 0;
            exp_forced++;
          end
        end else begin
          blocked = 0;
        end
        if (e_wr) void'(mq.pop_front());
        if (bus.e_fb_write && !e_full && !mis)
          mq.push_back(model_store(bus.e_addr, bus.e_wdata, bus.e_mem_size));
      end
    end
  end

  task automatic drive_idle();
    bus.e_fb_write = 1'b0;
    bus.e_addr     = '0;
    bus.e_wdata    = '0;
    bus.e_mem_size = MEM_BYTE;
    bus.so_req     = 1'b0;
    bus.so_addr    = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input int a, input logic [31:0] d, input mem_size_t s);
    bus.e_fb_write = 1'b1;
    bus.e_addr     = (ADDR_W+2)'(a);
    bus.e_wdata    = d;
    bus.e_mem_size = s;
  endtask

  initial begin
    int sent;
    bit prev_stall, prev_gnt;
    int so_pct;

    rst = 1'b1;
    drive_idle();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_fb_en", 32'(fb_en), 32'h0);
    check("rst_so_rvalid", 32'(bus.so_rvalid), 32'h0);
    check("rst_cpu_stall", 32'(bus.cpu_stall), 32'h0);

    // Byte store lands on lane 2 of word 1.
    step();
    store(32'h0006, 32'h000000AB, MEM_BYTE);
    @(negedge clk);
    check("t1_stall", 32'(bus.cpu_stall), 32'h0);
    check("t1_no_write_yet", 32'(fb_en), 32'h0);
    step();
    drive_idle();
    @(negedge clk);
    check("t1_we", 32'(fb_we), 32'h4);
    check("t1_addr", 32'(fb_addr), 32'h1);
    check("t1_wdata", fb_wdata, 32'hABABABAB);

    // Misaligned half and word stores are dropped with a pulse.
    step();
    store(32'h0003, 32'h1234, MEM_HALF);
    @(negedge clk);
    check("t2_half_mis", 32'(bus.fb_misalign), 32'h1);
    check("t2_half_stall", 32'(bus.cpu_stall), 32'h0);
    step();
    store(32'h0002, 32'hDEADBEEF, MEM_WORD);
    @(negedge clk);
    check("t2_word_mis", 32'(bus.fb_misalign), 32'h1);
    check("t2_no_ram", 32'(fb_en), 32'h0);
    step();
    drive_idle();
    @(negedge clk);
    check("t2_still_no_ram", 32'(fb_en), 32'h0);
    check("t2_pulse_end", 32'(bus.fb_misalign), 32'h0);

    // Scanout hogs the RAM; the queue fills, then one write is forced.
    step();
    bus.so_req  = 1'b1;
    bus.so_addr = 17'h1F00;
    sent = 0;
    for (int c = 1; c <= 12; c++) begin
      bus.e_fb_write = sent < 5;
      bus.e_addr     = (ADDR_W+2)'(32'h100 + sent * 4);
      bus.e_wdata    = 32'hC0DE0000 + 32'(sent);
      bus.e_mem_size = MEM_WORD;
      @(negedge clk);
      check($sformatf("t3_stall_c%0d", c), 32'(bus.cpu_stall), 32'(c >= 5 && c <= 10));
      check($sformatf("t3_gnt_c%0d", c), 32'(bus.so_gnt), 32'(c != 10));
      if (c == 10) begin
        check("t3_forced_we", 32'(fb_we), 32'hF);
        check("t3_forced_addr", 32'(fb_addr), 32'h40);
        check("t3_forced_wdata", fb_wdata, 32'hC0DE0000);
      end
      if (bus.e_fb_write && !bus.cpu_stall) sent++;
      step();
    end
    check("t3_all_sent", 32'(sent), 32'd5);
    drive_idle();
    repeat (6) step();

    // Continuous scanout with an empty queue: grant every cycle.
    for (int i = 0; i < 4; i++) begin
      bus.so_req  = 1'b1;
      bus.so_addr = ADDR_W'(i * 3 + 5);
      @(negedge clk);
      check("t4_gnt", 32'(bus.so_gnt), 32'h1);
      if (i > 0) begin
        check("t4_rvalid", 32'(bus.so_rvalid), 32'h1);
        check("t4_rdata", bus.so_rdata, ram_val(ADDR_W'((i - 1) * 3 + 5)));
      end
      step();
    end
    drive_idle();
    step();

    // Two queued, then push while writing: order preserved, no stall.
    bus.so_req = 1'b1;
    store(32'h200, 32'hA0, MEM_WORD);
    step();
    store(32'h204, 32'hA1, MEM_WORD);
    step();
    bus.so_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k < 2) store(32'h208 + k * 4, 32'hA2 + 32'(k), MEM_WORD);
      else bus.e_fb_write = 1'b0;
      @(negedge clk);
      check("t5_stall", 32'(bus.cpu_stall), 32'h0);
      check("t5_order", 32'(fb_addr), 32'h80 + 32'(k));
      step();
    end
    drive_idle();
    step();

    // Reset with three stores queued behind scanout.
    bus.so_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      store(32'h300 + k * 4, 32'(k), MEM_WORD);
      step();
    end
    drive_idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("t6_fb_en", 32'(fb_en), 32'h0);
    check("t6_rvalid", 32'(bus.so_rvalid), 32'h0);
    check("t6_stall", 32'(bus.cpu_stall), 32'h0);
`ifdef FB_ARB_STATS_EN
    check("t6_stat_stall", stat_stall_cycles, 32'h0);
    check("t6_stat_forced", 32'(stat_forced_wr), 32'h0);
`endif
    step();
    @(negedge clk);
    check("t6_flushed", 32'(fb_en), 32'h0);
    step();

    // Randomized traffic with hold-until-accepted requesters.
    prev_stall = 0;
    prev_gnt   = 0;
    for (int n = 0; n < 4000; n++) begin
      case (n / 1000)
        0:       so_pct = 20;
        1:       so_pct = 95;
        2:       so_pct = 50;
        default: so_pct = 100;
      endcase
      if (!(bus.e_fb_write && prev_stall)) begin
        bus.e_fb_write = ($urandom % 3) != 0;
        bus.e_addr     = (ADDR_W+2)'($urandom_range(0, 255));
        bus.e_wdata    = $urandom;
        bus.e_mem_size = mem_size_t'($urandom_range(0, 2));
      end
      if (!(bus.so_req && !prev_gnt)) begin
        bus.so_req  = int'($urandom % 100) < so_pct;
        bus.so_addr = ADDR_W'($urandom);
      end
      rst = ($urandom % 600) == 0;
      @(negedge clk);
      prev_stall = bus.cpu_stall;
      prev_gnt   = bus.so_gnt;
      step();
    end
    rst = 1'b0;
    drive_idle();
    repeat (8) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
